// File: rtl/mod5_rr_scheduler.sv
// Round-robin owner scheduler: one NREQ-wide one-hot grant, rotating pointer, hold-limit preemption.
// One clk from sampled request to grant; a free cycle always separates two owners.
module mod5_rr_scheduler #(
   parameter int NREQ     = 5,
   parameter int MAX_HOLD = 4,
   parameter int ID_W     = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            en,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] grant,
   output logic [ID_W-1:0] grant_id,
   output logic            busy,
   output logic            preempt,
   output logic [ID_W-1:0] ptr
);

   localparam int HW = $clog2(MAX_HOLD + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state_q, state_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic [ID_W-1:0]   gid_q, gid_d;
   logic              busy_q, busy_d;
   logic              preempt_q, preempt_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [HW-1:0]     hold_q, hold_d;

   logic              win_vld;
   logic [ID_W-1:0]   win_id;
   logic [NREQ-1:0]   win_onehot;
   int                idx;

   // Scan downward from the farthest candidate so the one nearest ptr is written last and wins.
   always_comb begin
      win_vld    = 1'b0;
      win_id     = '0;
      win_onehot = '0;
      idx        = 0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx = int'(ptr_q) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (req[idx]) begin
            win_vld = 1'b1;
            win_id  = ID_W'(idx);
         end
      end
      win_onehot[win_id] = 1'b1;
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      gid_d     = gid_q;
      busy_d    = busy_q;
      preempt_d = 1'b0;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      case (state_q)
         IDLE: begin
            if (en && win_vld) begin
               state_d = BUSY;
               grant_d = win_onehot;
               gid_d   = win_id;
               busy_d  = 1'b1;
               hold_d  = HW'(1);
            end
         end
         BUSY: begin
            if (!req[gid_q] || hold_q == HW'(MAX_HOLD)) begin
               state_d   = IDLE;
               grant_d   = '0;
               gid_d     = '0;
               busy_d    = 1'b0;
               preempt_d = req[gid_q];
               hold_d    = '0;
               ptr_d     = (gid_q == ID_W'(NREQ - 1)) ? '0 : gid_q + 1'b1;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         gid_q     <= '0;
         busy_q    <= 1'b0;
         preempt_q <= 1'b0;
         ptr_q     <= '0;
         hold_q    <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         gid_q     <= gid_d;
         busy_q    <= busy_d;
         preempt_q <= preempt_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
      end
   end

   assign grant    = grant_q;
   assign grant_id = gid_q;
   assign busy     = busy_q;
   assign preempt  = preempt_q;
   assign ptr      = ptr_q;

endmodule

// File: tb/tb_mod5_rr_scheduler.sv
// Directed bench for mod5_rr_scheduler (NREQ=5, MAX_HOLD=4) with hand-computed expectations.
module tb_mod5_rr_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic [4:0] req;
   logic [4:0] grant;
   logic [2:0] grant_id;
   logic       busy;
   logic       preempt;
   logic [2:0] ptr;

   int tests = 0;
   int fails = 0;
   bit inv_on = 1'b0;

   mod5_rr_scheduler #(.NREQ(5), .MAX_HOLD(4), .ID_W(3)) dut (
      .clk(clk), .reset(reset), .en(en), .req(req),
      .grant(grant), .grant_id(grant_id), .busy(busy),
      .preempt(preempt), .ptr(ptr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [4:0] g, input logic [2:0] id,
                          input logic b, input logic p, input logic [2:0] pt);
      chk({tag, ".grant"},    32'(grant),    32'(g));
      chk({tag, ".grant_id"}, 32'(grant_id), 32'(id));
      chk({tag, ".busy"},     32'(busy),     32'(b));
      chk({tag, ".preempt"},  32'(preempt),  32'(p));
      chk({tag, ".ptr"},      32'(ptr),      32'(pt));
   endtask

   // Structural invariants sampled mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (inv_on) begin
         chk("inv.onehot", 32'((grant & (grant - 5'd1)) == 5'd0), 32'd1);
         chk("inv.busy",   32'(busy), 32'(|grant));
         chk("inv.id",     32'(grant_id), 32'((grant == 5'd0) ? 0 : $clog2(grant)));
         chk("inv.preempt_idle", 32'(preempt && (grant != 5'd0)), 32'd0);
         chk("inv.ptr_range",    32'(ptr < 3'd5), 32'd1);
      end
   end

   initial begin
      reset = 1'b1; en = 1'b0; req = 5'b0;
      #2;
      chk_out("reset0", 5'b00000, 3'd0, 1'b0, 1'b0, 3'd0);
      tick();
      reset = 1'b0;
      inv_on = 1'b1;

      // Single request held for two sampling edges.
      en = 1'b1; req = 5'b00100;
      tick(); chk_out("single1", 5'b00100, 3'd2, 1'b1, 1'b0, 3'd0);
      tick(); chk_out("single2", 5'b00100, 3'd2, 1'b1, 1'b0, 3'd0);
      req = 5'b0;
      tick(); chk_out("single_rel", 5'b00000, 3'd0, 1'b0, 1'b0, 3'd3);

      // Asynchronous reset in the middle of a grant.
      req = 5'b00100;
      tick(); chk_out("pre_rst", 5'b00100, 3'd2, 1'b1, 1'b0, 3'd3);
      #2 reset = 1'b1;
      #1 chk_out("mid_rst", 5'b00000, 3'd0, 1'b0, 1'b0, 3'd0);
      #1 reset = 1'b0;
      tick(); chk_out("post_rst", 5'b00100, 3'd2, 1'b1, 1'b0, 3'd0);
      req = 5'b0;
      tick(); chk_out("post_rst_rel", 5'b00000, 3'd0, 1'b0, 1'b0, 3'd3);
      #2 reset = 1'b1;
      #2 reset = 1'b0;

      // Saturation: every owner runs 4 cycles, preempt pulse, one free cycle.
      req = 5'b11111;
      for (int k = 0; k < 6; k++) begin
         for (int c = 0; c < 4; c++) begin
            tick();
            chk_out($sformatf("sat_own%0d_c%0d", k, c), 5'(5'b1 << (k % 5)), 3'(k % 5),
                    1'b1, 1'b0, 3'(k % 5));
         end
         tick();
         chk_out($sformatf("sat_rel%0d", k), 5'b00000, 3'd0, 1'b0, 1'b1, 3'((k + 1) % 5));
      end
      req = 5'b0;
      tick(); chk_out("sat_idle", 5'b00000, 3'd0, 1'b0, 1'b0, 3'd1);

      // Wrap fairness: owner 4 releases so ptr wraps to 0, then 10001 -> 0.
      req = 5'b10000;
      tick(); chk("wrap_w4", 32'(grant_id), 32'd4);
      req = 5'b0;
      tick(); chk("wrap_ptr0", 32'(ptr), 32'd0);
      req = 5'b10001;
      tick(); chk("wrap_10001", 32'(grant_id), 32'd0);
      req = 5'b0;
      tick(); chk("wrap_ptr1", 32'(ptr), 32'd1);
      req = 5'b00100;
      tick(); chk("wrap_w2", 32'(grant_id), 32'd2);
      req = 5'b0;
      tick(); chk("wrap_ptr3", 32'(ptr), 32'd3);
      req = 5'b00011;
      tick(); chk_out("wrap_00011", 5'b00001, 3'd0, 1'b1, 1'b0, 3'd3);
      req = 5'b0;
      tick(); chk("wrap_ptr1b", 32'(ptr), 32'd1);

      // Enable gating, then en dropped while busy.
      en = 1'b0; req = 5'b01000;
      for (int c = 0; c < 10; c++) begin
         tick(); chk($sformatf("en0_c%0d", c), 32'(grant), 32'd0);
      end
      en = 1'b1;
      tick(); chk_out("en1", 5'b01000, 3'd3, 1'b1, 1'b0, 3'd1);
      en = 1'b0;
      req = 5'b01101;
      tick(); chk_out("en_busy1", 5'b01000, 3'd3, 1'b1, 1'b0, 3'd1);
      tick(); chk_out("en_busy2", 5'b01000, 3'd3, 1'b1, 1'b0, 3'd1);
      req = 5'b00101;
      tick(); chk_out("en_rel", 5'b00000, 3'd0, 1'b0, 1'b0, 3'd4);
      tick(); chk("en_off_idle", 32'(grant), 32'd0);

      // Release coincides with hold limit: normal release, no preempt.
      en = 1'b1; req = 5'b00010;
      for (int c = 0; c < 4; c++) begin
         tick(); chk_out($sformatf("lim_c%0d", c), 5'b00010, 3'd1, 1'b1, 1'b0, 3'd4);
      end
      req = 5'b0;
      tick(); chk_out("lim_rel", 5'b00000, 3'd0, 1'b0, 1'b0, 3'd2);
      tick(); chk_out("lim_after", 5'b00000, 3'd0, 1'b0, 1'b0, 3'd2);

      inv_on = 1'b0;
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mod5_rr_scheduler.md
Name: mod5_rr_scheduler

Overview:
- Round-robin scheduler that shares one resource between NREQ requesters, one owner at a time.
- A mod-NREQ priority pointer rotates past each served requester, giving starvation-free access.
- A hold-limit counter preempts any owner that keeps its grant longer than MAX_HOLD cycles.
- Sits in front of a shared datapath resource and drives its one-hot select.

Parameters:
- NREQ, 5, number of requesters; legal range 2..8.
- MAX_HOLD, 4, maximum consecutive grant cycles per ownership; legal range >= 1.
- ID_W, 3, width of grant_id; must satisfy 2**ID_W >= NREQ.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  allows new grants; does not abort a grant already running.
- req  input  NREQ  per-requester request level; held high while ownership is wanted.
- grant  output  NREQ  one-hot grant, registered; all zero when the resource is free.
- grant_id  output  ID_W  index of the current owner; 0 when grant is all zero.
- busy  output  1  high when grant is non-zero.
- preempt  output  1  one-cycle pulse marking a grant removed by the hold limit.
- ptr  output  ID_W  current round-robin pointer; first index searched.

Behaviour:
- Reset (async, any time, including mid-grant):
  - grant=0, grant_id=0, busy=0, preempt=0, ptr=0, hold_cnt=0, state=IDLE.
  - Takes effect immediately; the first grant is possible at the first clk edge after reset deasserts.
- State machine has two states, IDLE and BUSY. All outputs are registered.
- IDLE:
  - At a clk edge with en=1 and req!=0, the winner W is the first set bit searched circularly from ptr: ptr, ptr+1, ... NREQ-1, 0, ... ptr-1.
  - After that edge: grant=1<<W, grant_id=W, busy=1, hold_cnt=1, state=BUSY.
  - Latency is one clk from the sampled req to the visible grant.
  - If en=0 or req=0, stay in IDLE with outputs zero.
- BUSY: W is the current owner. At each clk edge:
  - Normal release: req[W]=0 -> grant=0, grant_id=0, busy=0, preempt=0, ptr=(W+1) mod NREQ, state=IDLE.
  - Preemption: req[W]=1 and hold_cnt==MAX_HOLD -> same as normal release, but preempt=1 for exactly the following cycle.
  - Otherwise keep the grant and set hold_cnt=hold_cnt+1.
- Resulting timing:
  - A grant lasts between 1 and MAX_HOLD cycles.
  - At least one all-zero grant cycle (turnaround) always separates two owners, even back-to-back.
- Simultaneous events:
  - req[W] dropping in the cycle hold_cnt==MAX_HOLD is a normal release: preempt=0.
  - en is ignored while BUSY; the current owner completes normally.
  - Requests from non-owners are ignored while BUSY.
  - Only req values present at the IDLE decision edge matter.
- Pointer:
  - Updates only on release, wrapping NREQ-1 -> 0.
  - Never takes values >= NREQ.
  - Unchanged while idle with no grant.
- Counter widths:
  - hold_cnt is sized for MAX_HOLD and never exceeds MAX_HOLD.
  - grant_id and ptr are zero-extended to ID_W.
- Invariants to check in the bench:
  - grant is always one-hot or zero.
  - busy == |grant.
  - grant_id is consistent with grant.
  - preempt is never high while grant is non-zero.

Test Plan:
- Reset: assert reset mid-cycle while grant=00100 -> immediately grant=00000, grant_id=0, busy=0, ptr=0, preempt=0; first grant occurs one edge after release.
- Single request: en=1, req=00100 held 2 cycles then dropped -> grant=00100 on the 2 cycles after the first sampling edge, then 00000, ptr=3, preempt never asserted.
- Saturation: en=1, req=11111 held -> grants 0,1,2,3,4,0 in order, each 4 cycles long, preempt pulse after each, one idle cycle between owners (period 5 cycles), ptr wraps 4 -> 0.
- Wrap fairness: after W=4 releases (ptr=0), req=10001 -> grant_id=0; with ptr=3 and req=00011 -> grant_id=0 (search 3,4,0).
- Enable gating: en=0 with req=01000 -> no grant for 10 cycles; raise en -> grant=01000 one edge later. Drop en during BUSY -> grant persists until req[3] falls.
- Release at limit: req[1] dropped in the same cycle hold_cnt==4 -> grant clears, preempt stays 0, ptr=2.
